sensor_serial_responder: RTL

Sensor-side end of the ToF sensor register link: an SPI slave (mode CPOL=0, CPHA=1, MSB first) that decodes 16-bit frames `{rw, addr[6:0], data[7:0]}` (rw=1 write, rw=0 read), holds an internal 8-bit register bank, and returns register contents on MISO during read frames. It serves as an on-FPGA sensor emulator for loopback bring-up of the serial controller, and as a register target for the analog or digital chip enable. All serial inputs are oversampled in the single system clock domain.

---
 rtl/sensor_serial_pkg.sv | 23 ++
 rtl/sensor_serial_responder_if.sv | 14 +
 rtl/sensor_serial_sync_edge.sv | 40 ++++
 rtl/sensor_serial_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sensor_serial_pkg.sv
// Shared definitions for the ToF sensor register link.
// Frame layout {rw, addr[6:0], data[7:0]}, MSB first. Used by both the
// responder (this block) and the serial controller on the host side.
package sensor_serial_pkg;

  localparam int   FRAME_W   = 16;
  localparam logic WRITE_BIT = 1'b1;
  localparam logic READ_BIT  = 1'b0;
  localparam int   RW_BIT    = 15;
  localparam int   ADDR_MSB  = 14;
  localparam int   ADDR_LSB  = 8;
  localparam int   DATA_MSB  = 7;
  localparam int   DATA_LSB  = 0;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE,
    ST_IDLE,
    ST_SHIFT,
    ST_HOLD,
    ST_ERR
  } state_t;

endpackage

// File: rtl/sensor_serial_responder_if.sv
// Serial link pins between the initiator (master) and the responder (slave).
//   ce_i   : chip enable, active high frame window
//   sclk_i : serial clock, idle low
//   sdi_i  : initiator -> responder data (MOSI)
//   sdo_o  : responder -> initiator data (MISO), always driven
interface sensor_serial_responder_if;
  logic ce_i;
  logic sclk_i;
  logic sdi_i;
  logic sdo_o;

  modport master (output ce_i, output sclk_i, output sdi_i, input sdo_o);
  modport slave  (input ce_i, input sclk_i, input sdi_i, output sdo_o);
endinterface

// File: rtl/sensor_serial_sync_edge.sv
// N-stage synchronizer with registered rise/fall strobes.
//   clk, rst : system clock, async active-high reset
//   d        : asynchronous input pin
//   q        : synchronized level, aligned with the strobes
//   rise     : 1-cycle pulse on a 0->1 transition of d
//   fall     : 1-cycle pulse on a 1->0 transition of d
// Pin edge to strobe is STAGES + 1 clocks. RESET_VAL lets an input that may
// be high during reset (chip enable) come out of reset without a false edge.
module sensor_serial_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
      prev_q <= RESET_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign q = prev_q;

endmodule

// File: rtl/sensor_serial_responder.sv
// SPI slave (CPOL=0, CPHA=1, MSB first) emulating the ToF sensor register
// bank. Decodes 16-bit frames {rw, addr, data}, writes the bank on commit of
// a write frame, and returns register contents on MISO during read frames.
// Ports:
//   clk, rst      : system clock (>= 8x sclk), async active-high reset
//   spi           : serial pins (slave modport)
//   host_addr_i   : local read address; host_rdata_o follows 1 clk later
//   wr_strobe_o   : write commit pulse, with held wr_addr_o / wr_data_o
//   rd_strobe_o   : read frame completion pulse
//   frame_err_o   : malformed frame pulse
//   err_count_o   : saturating malformed-frame count, only when
//                   SENSOR_SERIAL_RESPONDER_ERR_COUNT_EN is defined
//
// state        | meaning
// WAIT_IDLE    | after reset, waiting to see ce low before accepting frames
// IDLE         | ce low, waiting for ce assert
// SHIFT        | inside frame, fewer than 16 sclk falls seen
// HOLD         | exactly 16 falls seen, ce deassert commits
// ERR          | more than 16 falls, ce deassert flags an error
module sensor_serial_responder
  import sensor_serial_pkg::*;
#(
  parameter int DEPTH       = 128,
  parameter int SYNC_STAGES = 2
) (
  input  logic                            clk,
  input  logic                            rst,
  sensor_serial_responder_if.slave        spi,
  input  logic [6:0]                      host_addr_i,
  output logic [7:0]                      host_rdata_o,
  output logic                            wr_strobe_o,
  output logic [6:0]                      wr_addr_o,
  output logic [7:0]                      wr_data_o,
  output logic                            rd_strobe_o,
  output logic                            frame_err_o
`ifdef SENSOR_SERIAL_RESPONDER_ERR_COUNT_EN
  ,
  output logic [7:0]                      err_count_o
`endif
);

  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  state_t state_q, state_n;

  logic               ce_s, ce_asrt, ce_deasrt;
  logic               sclk_rise, sclk_fall, sdi_s;
  logic [2:0]         sync_unused;
  logic [4:0]         cnt_q;
  logic [FRAME_W-1:0] sr_q;
  logic [6:0]         addr_q;
  logic               rw_q;
  logic [7:0]         rd_byte_q;
  logic               sdo_q;
  logic               clr, do_commit, do_err;
  // Full 128-entry array; entries at or above DEPTH are never written and
  // never read, so they reduce to constants.
  logic [7:0]         mem_q [128];

  function automatic logic in_range(input logic [6:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  sensor_serial_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ce (
    .clk(clk), .rst(rst), .d(spi.ce_i), .q(ce_s), .rise(ce_asrt), .fall(ce_deasrt)
  );
  sensor_serial_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(spi.sclk_i), .q(sync_unused[0]), .rise(sclk_rise),
    .fall(sclk_fall)
  );
  sensor_serial_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(clk), .rst(rst), .d(spi.sdi_i), .q(sdi_s), .rise(sync_unused[1]),
    .fall(sync_unused[2])
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_WAIT_IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    clr       = 1'b0;
    do_commit = 1'b0;
    do_err    = 1'b0;
    case (state_q)
      ST_WAIT_IDLE: if (!ce_s) state_n = ST_IDLE;
      ST_IDLE: begin
        if (ce_asrt) begin
          clr     = 1'b1;
          state_n = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ce_deasrt) begin
          do_err  = 1'b1;
          state_n = ST_IDLE;
        end else if (sclk_fall && cnt_q == 5'd15) begin
          state_n = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (ce_deasrt) begin
          do_commit = 1'b1;
          state_n   = ST_IDLE;
        end else if (sclk_fall) begin
          state_n = ST_ERR;
        end
      end
      ST_ERR: begin
        if (ce_deasrt) begin
          do_err  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_WAIT_IDLE;
    endcase
  end

  // Shift/count datapath. Address and rw are captured on the 8th fall so the
  // read byte is ready well before the 9th rise starts driving it out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 5'd0;
      sr_q      <= '0;
      addr_q    <= 7'd0;
      rw_q      <= WRITE_BIT;
      rd_byte_q <= 8'h00;
    end else begin
      rd_byte_q <= in_range(addr_q) ? mem_q[addr_q] : 8'h00;
      if (clr) begin
        cnt_q <= 5'd0;
        sr_q  <= '0;
        rw_q  <= WRITE_BIT;
      end else if (sclk_fall && state_q inside {ST_SHIFT, ST_HOLD, ST_ERR}) begin
        if (cnt_q != 5'd17) cnt_q <= cnt_q + 5'd1;
        if (state_q == ST_SHIFT) begin
          sr_q <= {sr_q[FRAME_W-2:0], sdi_s};
          if (cnt_q == 5'd7) begin
            rw_q   <= sr_q[6];
            addr_q <= {sr_q[5:0], sdi_s};
          end
        end
      end
    end
  end

  // MISO: rises 9..16 of a read frame carry the read byte, everything else 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdo_q <= 1'b0;
    end else if (!ce_s) begin
      sdo_q <= 1'b0;
    end else if (sclk_rise) begin
      if (state_q == ST_SHIFT && rw_q == READ_BIT && cnt_q[3])
        sdo_q <= rd_byte_q[~cnt_q[2:0]];
      else
        sdo_q <= 1'b0;
    end
  end

  assign spi.sdo_o = sdo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_strobe_o <= 1'b0;
      rd_strobe_o <= 1'b0;
      frame_err_o <= 1'b0;
      wr_addr_o   <= 7'd0;
      wr_data_o   <= 8'h00;
      for (int i = 0; i < 128; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_strobe_o <= 1'b0;
      rd_strobe_o <= 1'b0;
      frame_err_o <= do_err;
      if (do_commit) begin
        if (sr_q[RW_BIT] == WRITE_BIT) begin
          wr_strobe_o <= 1'b1;
          wr_addr_o   <= sr_q[ADDR_MSB:ADDR_LSB];
          wr_data_o   <= sr_q[DATA_MSB:DATA_LSB];
          if (in_range(sr_q[ADDR_MSB:ADDR_LSB]))
            mem_q[sr_q[ADDR_MSB:ADDR_LSB]] <= sr_q[DATA_MSB:DATA_LSB];
        end else begin
          rd_strobe_o <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) host_rdata_o <= 8'h00;
    else     host_rdata_o <= in_range(host_addr_i) ? mem_q[host_addr_i] : 8'h00;
  end

`ifdef SENSOR_SERIAL_RESPONDER_ERR_COUNT_EN
  // Counts alongside frame_err_o so both change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              err_count_o <= 8'h00;
    else if (do_err && err_count_o != 8'hFF) err_count_o <= err_count_o + 8'h01;
  end
`endif

endmodule
